// File: rtl/register_pkg.sv
// Shared constants and the parity helper for the register block.
package register_pkg;

    localparam int REG_DEFAULT_W = 8;

    // Even parity of a value zero-extended to 64 bits.
    function automatic logic parity_even(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/register_parity.sv
// Registered even parity of the next value of the data register.
module register_parity
    import register_pkg::*;
#(
    parameter int             N           = REG_DEFAULT_W,
    parameter logic [N-1:0]   RESET_VALUE = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] data_nxt,
    output logic         par
);

    logic [63:0] reset_ext_s;
    logic [63:0] data_ext_s;

    assign reset_ext_s = 64'(RESET_VALUE);
    assign data_ext_s  = 64'(data_nxt);

    // Parity tracks the same edge as the data flops it describes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= parity_even(reset_ext_s);
        end else begin
            par <= parity_even(data_ext_s);
        end
    end

endmodule

// File: rtl/register.sv
// Loadable N-bit register with clear and a load-seen flag.
// Optional registered parity output enabled by macro REGISTER_PARITY_EN.
module register
    import register_pkg::*;
#(
    parameter int             N           = REG_DEFAULT_W,
    parameter logic [N-1:0]   RESET_VALUE = {N{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic         clr,
    input  logic [N-1:0] in,
    output logic [N-1:0] out,
`ifdef REGISTER_PARITY_EN
    output logic         par,
`endif
    output logic         vld
);

    logic [N-1:0] data_nxt_s;
    logic         vld_nxt_s;

    // Clear beats load; otherwise hold.
    always_comb begin
        data_nxt_s = out;
        vld_nxt_s  = vld;
        if (clr) begin
            data_nxt_s = {N{1'b0}};
            vld_nxt_s  = 1'b0;
        end else if (ld) begin
            data_nxt_s = in;
            vld_nxt_s  = 1'b1;
        end else begin
            data_nxt_s = out;
            vld_nxt_s  = vld;
        end
    end

    // Data and flag flops; reset overrides clear and load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= RESET_VALUE;
            vld <= 1'b0;
        end else begin
            out <= data_nxt_s;
            vld <= vld_nxt_s;
        end
    end

`ifdef REGISTER_PARITY_EN
    register_parity #(
        .N           (N),
        .RESET_VALUE (RESET_VALUE)
    ) u_parity (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_nxt (data_nxt_s),
        .par      (par)
    );
`endif

endmodule

// File: tb/tb_register.sv
// Directed self-checking bench for register (N=8, RESET_VALUE=0).
module tb_register;

    logic       clk;
    logic       rst_n;
    logic       ld;
    logic       clr;
    logic [7:0] in;
    logic [7:0] out;
    logic       vld;
`ifdef REGISTER_PARITY_EN
    logic       par;
`endif

    int n_checks;
    int n_fail;

    register #(
        .N           (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ld    (ld),
        .clr   (clr),
        .in    (in),
        .out   (out),
`ifdef REGISTER_PARITY_EN
        .par   (par),
`endif
        .vld   (vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        ld    = 1'b0;
        clr   = 1'b0;
        in    = 8'h00;

        tick();
        check_eq("reset_out", 64'(out), 64'h00);
        check_eq("reset_vld", 64'(vld), 64'h0);
`ifdef REGISTER_PARITY_EN
        check_eq("reset_par", 64'(par), 64'h0);
`endif

        rst_n = 1'b1;
        in    = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("noload_out", 64'(out), 64'h00);
            check_eq("noload_vld", 64'(vld), 64'h0);
        end

        ld = 1'b1;
        tick();
        check_eq("load_aa_out", 64'(out), 64'hAA);
        check_eq("load_aa_vld", 64'(vld), 64'h1);
`ifdef REGISTER_PARITY_EN
        check_eq("load_aa_par", 64'(par), 64'h0);
`endif

        ld = 1'b0;
        in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("hold_out", 64'(out), 64'hAA);
            check_eq("hold_vld", 64'(vld), 64'h1);
        end

        ld = 1'b1;
        tick();
        check_eq("load_00_out", 64'(out), 64'h00);
        check_eq("load_00_vld", 64'(vld), 64'h1);

        in = 8'h01;
        tick();
        check_eq("track_01", 64'(out), 64'h01);
`ifdef REGISTER_PARITY_EN
        check_eq("load_01_par", 64'(par), 64'h1);
`endif
        in = 8'h02;
        #2;
        check_eq("no_comb_path", 64'(out), 64'h01);
        tick();
        check_eq("track_02", 64'(out), 64'h02);
        in = 8'h03;
        tick();
        check_eq("track_03", 64'(out), 64'h03);
        tick();
        check_eq("reload_same", 64'(out), 64'h03);

        clr = 1'b1;
        in  = 8'h55;
        tick();
        check_eq("clr_ld_out", 64'(out), 64'h00);
        check_eq("clr_ld_vld", 64'(vld), 64'h0);
`ifdef REGISTER_PARITY_EN
        check_eq("clr_par", 64'(par), 64'h0);
`endif

        clr = 1'b0;
        ld  = 1'b0;
        tick();
        check_eq("after_clr_vld", 64'(vld), 64'h0);

        ld = 1'b1;
        tick();
        check_eq("load_55_out", 64'(out), 64'h55);
        check_eq("load_55_vld", 64'(vld), 64'h1);

        rst_n = 1'b0;
        in    = 8'h77;
        tick();
        check_eq("rst_ld_out", 64'(out), 64'h00);
        check_eq("rst_ld_vld", 64'(vld), 64'h0);

        rst_n = 1'b1;
        in    = 8'h81;
        tick();
        check_eq("load_81_out", 64'(out), 64'h81);
        rst_n = 1'b0;
        clr   = 1'b1;
        tick();
        check_eq("rst_clr_ld_out", 64'(out), 64'h00);
        check_eq("rst_clr_ld_vld", 64'(vld), 64'h0);

        rst_n = 1'b1;
        clr   = 1'b0;
        ld    = 1'b0;
        tick();
        check_eq("idle_after_rst", 64'(out), 64'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 The block SHALL have parameter N, default 8, data width in bits, legal range 1..64.
REQ-002 The block SHALL have parameter RESET_VALUE, default all-zeros, the value of out after reset, N bits wide.
REQ-003 The block SHALL use one clock and a synchronous, active-low reset.
REQ-004 Port clk SHALL be an input, 1 bit wide, the rising-edge clock.
REQ-005 Port rst_n SHALL be an input, 1 bit wide, the synchronous active-low reset.
REQ-006 Port ld SHALL be an input, 1 bit wide, the load enable.
REQ-007 Port clr SHALL be an input, 1 bit wide, a synchronous clear to all-zeros.
REQ-008 Port in SHALL be an input, N bits wide, the data to load.
REQ-009 Port out SHALL be an output, N bits wide, the stored value, driven directly from flops.
REQ-010 Port vld SHALL be an output, 1 bit wide; it is high once at least one load has occurred since reset.

Function
REQ-011 All state SHALL update only on the rising edge of clk.
REQ-012 Priority at each edge SHALL be rst_n low, then clr high, then ld high, then hold.
REQ-013 When ld=1 and clr=0, out SHALL equal the in value sampled at that edge, with one-edge latency.
REQ-014 When ld=0 and clr=0, out SHALL hold its value regardless of changes on in.
REQ-015 When clr=1, out SHALL become all-zeros and vld SHALL become 0 at that edge, even if ld=1 at the same edge.
REQ-016 Loading SHALL set vld to 1; vld SHALL stay 1 until the next reset or clear.
REQ-017 No combinational path SHALL exist from in or ld to out.
REQ-018 When ld is held high continuously, out SHALL track in with a one-cycle delay.
REQ-019 Loading a value equal to the current contents SHALL be legal and leave out unchanged.

Reset
REQ-020 At a rising edge where rst_n=0, out SHALL become RESET_VALUE and vld SHALL become 0.
REQ-021 Reset SHALL override clr and ld asserted at the same edge.
REQ-022 Asserting reset mid-operation SHALL discard stored data; no load occurs at that edge.
REQ-023 Before the first reset edge, out SHALL be unspecified; benches SHALL not check out before then.

Configuration
REQ-024 Macro REGISTER_PARITY_EN SHALL control an optional parity output.
REQ-025 With REGISTER_PARITY_EN defined, the block SHALL add port par, an output 1 bit wide, the registered even parity of out (XOR of all bits of out), updated at the same edge as out.
REQ-026 With REGISTER_PARITY_EN defined, par SHALL reset to the parity of RESET_VALUE and SHALL be 0 after a clear.
REQ-027 Without REGISTER_PARITY_EN, port par and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package register_pkg SHALL hold the constant REG_DEFAULT_W = 8 and the parity function.
REQ-029 The register SHALL be a single flat module; the optional parity logic MAY be a sub-module named register_parity.

Verification
REQ-030 Scenario: N=8, rst_n=0 for one edge -> out=0x00, vld=0.
REQ-031 Scenario: in=0xAA, ld=0 for 2 cycles -> out stays 0x00; then ld=1 -> out=0xAA and vld=1 after the next edge.
REQ-032 Scenario: in=0x00 and ld=0 at the same time -> out holds 0xAA for 4 cycles; then ld=1 -> out=0x00 after the next edge.
REQ-033 Scenario: ld=1 with in changing every cycle (0x01, 0x02, 0x03) -> out follows with one-cycle lag.
REQ-034 Scenario: clr=1 and ld=1 with in=0x55 -> out=0x00, vld=0; rst_n=0 together with ld=1 -> out=RESET_VALUE.
REQ-035 Scenario: with REGISTER_PARITY_EN defined, load 0xAA -> par=0; load 0x01 -> par=1.
